// File: rtl/layer_feeder.sv
// Receive-side feeder between two neuron layers: captures upstream vectors
// into a two-slot buffer and serializes them word by word downstream.
module layer_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic             new_out,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       idx_out,
  output logic             last_out,
  output logic             valid_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             overflow
);

  localparam int DEPTH = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH][4];
  logic [WIDTH-1:0] vin [4];
  logic [WIDTH-1:0] next_head [4];

  logic [0:0] state;
  logic       rdy_q;
  logic       outstanding;
  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic [1:0] count_nx;
  logic       cap;
  logic       wr;
  logic       pop;
  logic       req;

  always_comb begin
    vin[0] = in1;
    vin[1] = in2;
    vin[2] = in3;
    vin[3] = in4;
  end

  always_comb begin
    cap = ready_in & ~rdy_q;
    wr  = cap & (count != 2'd2);
    pop = (state == SEND) & ack_in & (idx_out == 2'd3);
    req = ~outstanding & ~new_out & (count != 2'd2) & ~cap;
    count_nx = count;
    if (wr & ~pop)
      count_nx = count + 2'd1;
    else if (~wr & pop)
      count_nx = count - 2'd1;
  end

  // The slot after the head may be written on the very edge the head pops.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (wr && count == 2'd1)
        next_head[i] = vin[i];
      else
        next_head[i] = mem[~rptr][i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < 4; i++)
        mem[wptr][i] <= vin[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      outstanding <= 1'b0;
      new_out     <= 1'b0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= 2'd0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rdy_q   <= ready_in;
      new_out <= req;
      if (cap)
        outstanding <= 1'b0;
      else if (new_out)
        outstanding <= 1'b1;
      if (wr)
        wptr <= ~wptr;
      if (pop)
        rptr <= ~rptr;
      if (cap && count == 2'd2)
        overflow <= 1'b1;
      count <= count_nx;
      busy  <= (count_nx != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      data_out  <= '0;
      idx_out   <= 2'd0;
      last_out  <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (count != 2'd0) begin
            state     <= SEND;
            valid_out <= 1'b1;
            idx_out   <= 2'd0;
            last_out  <= 1'b0;
            data_out  <= mem[rptr][0];
          end
        end
        state == SEND: begin
          if (ack_in && idx_out != 2'd3) begin
            idx_out  <= idx_out + 2'd1;
            data_out <= mem[rptr][idx_out + 2'd1];
            last_out <= (idx_out == 2'd2);
          end else if (pop && count_nx != 2'd0) begin
            idx_out  <= 2'd0;
            last_out <= 1'b0;
            data_out <= next_head[0];
          end else if (pop) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            idx_out   <= 2'd0;
            last_out  <= 1'b0;
            data_out  <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_feeder.sv
// Directed testbench for layer_feeder: request pulses, streaming,
// backpressure, two-slot buffering, overflow and mid-stream reset.
module tb_layer_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready_in;
  logic [7:0] in1, in2, in3, in4;
  logic       new_out;
  logic [7:0] data_out;
  logic [1:0] idx_out;
  logic       last_out;
  logic       valid_out;
  logic       ack_in;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int np;
  int cyc;
  bit found;
  logic [7:0] exp_w [8];
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  layer_feeder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready_in  (ready_in),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .new_out   (new_out),
    .data_out  (data_out),
    .idx_out   (idx_out),
    .last_out  (last_out),
    .valid_out (valid_out),
    .ack_in    (ack_in),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    in1 = a;
    in2 = b;
    in3 = c;
    in4 = d;
    ready_in = 1'b1;
    step();
  endtask

  task automatic drain(input int n, input bit bp, output int cy);
    int k;
    int pi;
    bit started;
    k = 0;
    pi = 0;
    started = 1'b0;
    cy = 0;
    for (int t = 0; t < 80 && k < n; t++) begin
      if (new_out) np++;
      if (valid_out) begin
        started = 1'b1;
        check("data", data_out, exp_w[k]);
        check("idx", idx_out, k % 4);
        check("last", last_out, (k % 4 == 3));
        ack_in = bp ? pat[pi % 7] : 1'b1;
        pi++;
        if (ack_in) k++;
      end else begin
        ack_in = bp ? 1'b0 : 1'b1;
      end
      if (started) cy++;
      step();
    end
    ack_in = 1'b0;
    check("drain_done", k, n);
  endtask

  initial begin
    rst_n = 1'b0;
    ready_in = 1'b0;
    ack_in = 1'b0;
    in1 = '0;
    in2 = '0;
    in3 = '0;
    in4 = '0;
    np = 0;
    step();
    step();
    check("rst_outs", {new_out, valid_out, data_out, idx_out,
                       last_out, busy, overflow}, 0);

    rst_n = 1'b1;
    step();
    check("new_first", new_out, 1);
    check("valid_idle", valid_out, 0);
    step();
    check("new_once", new_out, 0);
    repeat (3) step();
    check("new_quiet", new_out, 0);
    check("busy_idle", busy, 0);

    // single vector, ack held high
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    ack_in = 1'b1;
    feed(8'h11, 8'h22, 8'h33, 8'h44);
    check("busy_cap", busy, 1);
    check("valid_cap", valid_out, 0);
    step();
    check("valid_lat", valid_out, 1);
    drain(4, 1'b0, cyc);
    check("nobubble1", cyc, 4);
    check("valid_end1", valid_out, 0);
    check("busy_end1", busy, 0);
    ready_in = 1'b0;
    step();

    // backpressure
    feed(8'h11, 8'h22, 8'h33, 8'h44);
    drain(4, 1'b1, cyc);
    check("valid_end2", valid_out, 0);
    check("busy_end2", busy, 0);
    ready_in = 1'b0;
    step();

    // two buffered vectors plus a dropped third
    exp_w[0] = 8'hA0; exp_w[1] = 8'hA1; exp_w[2] = 8'hA2; exp_w[3] = 8'hA3;
    exp_w[4] = 8'hB0; exp_w[5] = 8'hB1; exp_w[6] = 8'hB2; exp_w[7] = 8'hB3;
    ack_in = 1'b0;
    feed(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    ready_in = 1'b0;
    step();
    check("new_after_a", new_out, 1);
    feed(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("new_full", new_out, 0);
      check("hold_a0", data_out, 8'hA0);
    end
    feed(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    check("overflow_set", overflow, 1);
    ready_in = 1'b0;
    step();
    np = 0;
    drain(8, 1'b0, cyc);
    check("nobubble2", cyc, 8);
    check("new_once_ab", np, 1);
    check("overflow_held", overflow, 1);
    check("busy_end3", busy, 0);

    // reset in the middle of a vector
    ack_in = 1'b1;
    feed(8'hD0, 8'hD1, 8'hD2, 8'hD3);
    ready_in = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (valid_out && idx_out == 2'd2) found = 1'b1;
      else step();
    end
    check("reach_idx2", found, 1);
    check("data_idx2", data_out, 8'hD2);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {new_out, valid_out, data_out, idx_out,
                      last_out, busy, overflow}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("new_after_rst", new_out, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_residual", {valid_out, busy}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_feeder.md
# layer_feeder

The layer_feeder sits on the receiving side of the inter-layer link between two neuron layers. It accepts the four 8-bit results and the `ready` level produced by the inter-layer collector, and it buffers up to two result vectors. It streams each vector one word at a time to the next layer's shared neuron over a valid/ack handshake. It also generates the one-cycle `new` request that tells the upstream layer to start computing its next sample.

## Interface
Parameters:
- `WIDTH`, default 8: width of each data word.
- `DEPTH`, fixed at 2: number of vector slots. Not overridable.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `ready_in`, input, 1 bit: level from the upstream collector. A rising edge means the vector is complete.
- `in1`..`in4`, input, WIDTH bits each: the upstream vector. Stable while `ready_in` is high.
- `new_out`, output, 1 bit: one-cycle pulse requesting the next upstream sample.
- `data_out`, output, WIDTH bits: current word to the downstream neuron.
- `idx_out`, output, 2 bits: index of the current word, 0..3 (0 = `in1`).
- `last_out`, output, 1 bit: high when `idx_out` == 3 and `valid_out` is high.
- `valid_out`, output, 1 bit: `data_out` is valid.
- `ack_in`, input, 1 bit: the downstream neuron accepts `data_out` in this cycle.
- `busy`, output, 1 bit: high when the FIFO holds at least one vector.
- `overflow`, output, 1 bit: sticky flag. Set when a vector is dropped.

## Operation
- **Edge detect.** A register `rdy_q` holds the previous value of `ready_in`. A capture event is `ready_in & ~rdy_q`. A level held high produces exactly one event.
- **FIFO.**
  - Two slots, each 4×WIDTH. Write pointer, read pointer and a `count` of 0..2.
  - On a capture event with `count`<2, the vector is written in the same edge and `count` increments.
  - On a capture event with `count`==2, the vector is dropped, `overflow` is set to 1 and `count` is unchanged.
  - A write and a pop in the same cycle leave `count` unchanged. Both pointers wrap from 1 to 0.
- **Request logic.**
  - An `outstanding` flag is set when `new_out` pulses and cleared on a capture event.
  - `new_out` is registered. It pulses for one cycle when `outstanding`==0, `count`<2 and no capture event occurs in that cycle.
  - Never two `new_out` pulses without an intervening capture event.
- **Serializer FSM.** States are IDLE and SEND. A 2-bit counter `idx` drives `idx_out`.
  - IDLE to SEND when `count`>0. Set `idx`=0.
  - In SEND, `valid_out`=1 and `data_out` = word `idx` of the head slot.
  - In SEND with `ack_in`=1 and `idx`<3: `idx` increments.
  - In SEND with `ack_in`=1 and `idx`==3: pop the head. If the post-pop `count` > 0, stay in SEND with `idx`=0. Otherwise go to IDLE.
  - In SEND with `ack_in`=0: hold. `data_out` and `idx_out` must not change.
  - `ack_in` is ignored in IDLE.
- **Width.** Data is passed through unmodified, with no arithmetic.
- **Reset (asynchronous).**
  - Outputs: `new_out`=0, `valid_out`=0, `data_out`=0, `idx_out`=0, `last_out`=0, `busy`=0, `overflow`=0.
  - State: `count`=0, pointers=0, `outstanding`=0, `rdy_q`=0, FSM in IDLE.
- **Reset mid-stream.** Asserting reset mid-stream discards every buffered vector immediately, with no partial completion.

## Timing
- The first `new_out` pulse comes on the first rising edge after `rst_n` deasserts. It is high for cycle 1 only.
- Capture happens on the edge where the event is detected. `busy` goes to 1 on that same edge.
- First-word latency: `valid_out` goes to 1 one cycle after the capture edge when the FIFO was empty and the FSM was in IDLE.
- With `ack_in` held at 1, a vector drains in 4 cycles and back-to-back vectors stream with no bubble.
- After the final pop, `busy` and `valid_out` fall on the same edge.
- The next `new_out` comes one cycle after `outstanding` clears, provided `count`<2.
- All outputs are registered, so there is no combinational path from `ack_in` or `ready_in` to any output.

## Test plan
- **Reset and request.** Release `rst_n`. Expect `new_out`=1 for exactly cycle 1 and 0 afterwards. All other outputs stay 0.
- **Single vector, ack held high.**
  - Stimulus: `in1..4` = 0x11, 0x22, 0x33, 0x44; raise `ready_in`.
  - Expect `data_out` = 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, `idx_out` 0..3, and `last_out` only on 0x44.
  - Then `valid_out`=0 and `busy`=0.
- **Backpressure.**
  - Stimulus: toggle `ack_in` 1,0,0,1,1,0,1.
  - Expect each word held stable while `ack_in`=0. The sequence is still 0x11, 0x22, 0x33, 0x44 with no repeats or skips.
- **Two buffered vectors.**
  - Stimulus: hold `ack_in`=0, capture A (0xA0–0xA3), then capture B (0xB0–0xB3); set `ack_in`=1.
  - Expect `count` to reach 2 and no `new_out` while full.
  - Expect 8 words A then B with no bubble. `new_out` pulses once after A pops.
- **Overflow.**
  - Stimulus: with `count`==2, a third `ready_in` rising edge carrying C (0xC0).
  - Expect `overflow`=1 and held. C is never emitted and the A and B streams are unchanged.
- **Reset mid-stream.** Assert `rst_n`=0 while `idx_out`==2. Expect every output to be 0 immediately. After release, expect a new `new_out` pulse and no residual words.
